// File: rtl/fetch_ram_1p_arb.sv
// Single-port fetch buffer: round-robin write/read arbitration, byte-masked writes, clear sweep.
// Optional macro FETCH_RAM_OUT_REG_EN adds one output register stage (read latency 2).
module fetch_ram_1p_arb #(
    parameter  int WORD_WIDTH = 128,
    parameter  int ADDR_WIDTH = 5,
    localparam int MASK_WIDTH = WORD_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  clr_i,
    output logic                  init_done_o,
    input  logic                  wr_val_i,
    output logic                  wr_rdy_o,
    input  logic [ADDR_WIDTH-1:0] wr_adr_i,
    input  logic [MASK_WIDTH-1:0] wr_msk_i,
    input  logic [WORD_WIDTH-1:0] wr_dat_i,
    input  logic                  rd_val_i,
    output logic                  rd_rdy_o,
    input  logic [ADDR_WIDTH-1:0] rd_adr_i,
    output logic                  rd_val_o,
    output logic [WORD_WIDTH-1:0] rd_dat_o
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] CNT_LAST = '1;

    typedef enum logic {
        S_INIT,
        S_IDLE
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic                  r_last_gnt_wr;
    logic                  r_init_done;
    logic [WORD_WIDTH-1:0] r_mem [DEPTH];
    logic                  r_rd_val;
    logic [WORD_WIDTH-1:0] r_rd_dat;

    logic                  w_serve;
    logic                  w_contend;
    logic                  w_wr_gnt;
    logic                  w_rd_gnt;
    logic                  w_init_wr;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_INIT:  if (!clr_i && (r_cnt == CNT_LAST)) w_state_nxt = S_IDLE;
            S_IDLE:  if (clr_i) w_state_nxt = S_INIT;
            default: w_state_nxt = S_INIT;
        endcase
    end

    // No grant is issued in a clr_i cycle; on contention the side not granted last wins.
    always_comb begin
        w_init_wr = (r_state == S_INIT);
        w_serve   = (r_state == S_IDLE) && !clr_i;
        w_contend = wr_val_i && rd_val_i;
        w_wr_gnt  = w_serve && wr_val_i && (!rd_val_i || !r_last_gnt_wr);
        w_rd_gnt  = w_serve && rd_val_i && (!wr_val_i || r_last_gnt_wr);
    end

    assign wr_rdy_o    = w_wr_gnt;
    assign rd_rdy_o    = w_rd_gnt;
    assign init_done_o = r_init_done;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt         <= '0;
            r_last_gnt_wr <= 1'b0;
            r_init_done   <= 1'b0;
        end else begin
            if ((r_state == S_INIT) && !clr_i) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end
            if (w_contend && (w_wr_gnt || w_rd_gnt)) begin
                r_last_gnt_wr <= w_wr_gnt;
            end
            r_init_done <= (w_state_nxt == S_IDLE);
        end
    end

    always_ff @(posedge clk) begin
        if (w_init_wr) begin
            r_mem[r_cnt] <= '0;
        end else if (w_wr_gnt) begin
            for (int unsigned i = 0; i < MASK_WIDTH; i++) begin
                if (wr_msk_i[i]) begin
                    r_mem[wr_adr_i][8*i +: 8] <= wr_dat_i[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rd_val <= 1'b0;
            r_rd_dat <= '0;
        end else begin
            r_rd_val <= w_rd_gnt;
            if (w_rd_gnt) begin
                r_rd_dat <= r_mem[rd_adr_i];
            end
        end
    end

`ifdef FETCH_RAM_OUT_REG_EN
    logic                  r_rd_val_q;
    logic [WORD_WIDTH-1:0] r_rd_dat_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rd_val_q <= 1'b0;
            r_rd_dat_q <= '0;
        end else begin
            r_rd_val_q <= r_rd_val;
            if (r_rd_val) begin
                r_rd_dat_q <= r_rd_dat;
            end
        end
    end

    assign rd_val_o = r_rd_val_q;
    assign rd_dat_o = r_rd_dat_q;
`else
    assign rd_val_o = r_rd_val;
    assign rd_dat_o = r_rd_dat;
`endif

endmodule

// File: tb/tb_fetch_ram_1p_arb.sv
// Directed self-checking bench for fetch_ram_1p_arb (default parameters).
module tb_fetch_ram_1p_arb;

`ifdef FETCH_RAM_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    localparam logic [127:0] EXP_MIX = {{8{8'hAA}}, {8{8'h55}}};

    logic         clk;
    logic         rstn;
    logic         clr_i;
    logic         init_done_o;
    logic         wr_val_i;
    logic         wr_rdy_o;
    logic [4:0]   wr_adr_i;
    logic [15:0]  wr_msk_i;
    logic [127:0] wr_dat_i;
    logic         rd_val_i;
    logic         rd_rdy_o;
    logic [4:0]   rd_adr_i;
    logic         rd_val_o;
    logic [127:0] rd_dat_o;

    int checks;
    int failures;

    fetch_ram_1p_arb #(.WORD_WIDTH(128), .ADDR_WIDTH(5)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .clr_i       (clr_i),
        .init_done_o (init_done_o),
        .wr_val_i    (wr_val_i),
        .wr_rdy_o    (wr_rdy_o),
        .wr_adr_i    (wr_adr_i),
        .wr_msk_i    (wr_msk_i),
        .wr_dat_i    (wr_dat_i),
        .rd_val_i    (rd_val_i),
        .rd_rdy_o    (rd_rdy_o),
        .rd_adr_i    (rd_adr_i),
        .rd_val_o    (rd_val_o),
        .rd_dat_o    (rd_dat_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic step_extra();
        if (LAT == 2) step();
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic exp_rv;
        checks   = 0;
        failures = 0;
        rstn     = 1'b0;
        clr_i    = 1'b0;
        wr_val_i = 1'b0;
        wr_adr_i = '0;
        wr_msk_i = '0;
        wr_dat_i = '0;
        rd_val_i = 1'b0;
        rd_adr_i = '0;
        step();
        step();

        // reset values
        rd_val_i = 1'b1;
        rd_adr_i = 5'd7;
        #1;
        check("rst_wr_rdy", wr_rdy_o, 1'b0);
        check("rst_rd_rdy", rd_rdy_o, 1'b0);
        check("rst_init_done", init_done_o, 1'b0);
        check("rst_rd_val", rd_val_o, 1'b0);
        check("rst_rd_dat", rd_dat_o, 128'h0);

        // post-reset clear sweep with a read held pending
        rstn = 1'b1;
        for (int i = 0; i < 32; i++) begin
            check("init_rd_rdy_low", rd_rdy_o, 1'b0);
            check("init_done_low", init_done_o, 1'b0);
            step();
        end
        check("init_done_rise", init_done_o, 1'b1);
        check("init_rd_rdy_high", rd_rdy_o, 1'b1);
        step();
        rd_val_i = 1'b0;
        step_extra();
        check("init_rd_val", rd_val_o, 1'b1);
        check("init_rd_dat_zero", rd_dat_o, 128'h0);

        // masked write then read back
        wr_val_i = 1'b1;
        wr_adr_i = 5'd3;
        wr_msk_i = '1;
        wr_dat_i = {16{8'hAA}};
        #1;
        check("mw_rdy0", wr_rdy_o, 1'b1);
        step();
        wr_msk_i = 16'h00FF;
        wr_dat_i = {16{8'h55}};
        #1;
        check("mw_rdy1", wr_rdy_o, 1'b1);
        step();
        wr_val_i = 1'b0;
        rd_val_i = 1'b1;
        rd_adr_i = 5'd3;
        #1;
        check("mw_rd_rdy", rd_rdy_o, 1'b1);
        step();
        rd_val_i = 1'b0;
        step_extra();
        check("mw_rd_val", rd_val_o, 1'b1);
        check("mw_rd_dat", rd_dat_o, EXP_MIX);
        step();
        check("mw_rd_val_pulse", rd_val_o, 1'b0);
        check("mw_rd_dat_hold", rd_dat_o, EXP_MIX);

        // continuous contention: W,R,W,R,W,R
        wr_adr_i = 5'd10;
        wr_msk_i = '1;
        wr_dat_i = {16{8'h3C}};
        rd_adr_i = 5'd3;
        for (int k = 0; k < 6 + LAT; k++) begin
            wr_val_i = (k < 6);
            rd_val_i = (k < 6);
            #1;
            if (k < 6) begin
                check("cont_wr_rdy", wr_rdy_o, (k % 2) == 0);
                check("cont_rd_rdy", rd_rdy_o, (k % 2) == 1);
            end
            exp_rv = (k >= LAT) && (((k - LAT) % 2) == 1);
            check("cont_rd_val", rd_val_o, exp_rv);
            if (exp_rv) check("cont_rd_dat", rd_dat_o, EXP_MIX);
            step();
        end

        // uncontended write must not move the round-robin pointer (last = read)
        wr_val_i = 1'b1;
        wr_adr_i = 5'd12;
        wr_dat_i = 128'h77;
        #1;
        check("rr_solo_wr", wr_rdy_o, 1'b1);
        step();
        rd_val_i = 1'b1;
        rd_adr_i = 5'd3;
        #1;
        check("rr_cont_wr", wr_rdy_o, 1'b1);
        check("rr_cont_rd", rd_rdy_o, 1'b0);
        step();
        wr_val_i = 1'b0;
        rd_val_i = 1'b0;

        // back-to-back read after write at the top address
        wr_val_i = 1'b1;
        wr_adr_i = 5'd31;
        wr_dat_i = 128'h1234;
        #1;
        check("raw_wr_rdy", wr_rdy_o, 1'b1);
        step();
        wr_val_i = 1'b0;
        rd_val_i = 1'b1;
        rd_adr_i = 5'd31;
        #1;
        check("raw_rd_rdy", rd_rdy_o, 1'b1);
        step();
        rd_val_i = 1'b0;
        step_extra();
        check("raw_rd_val", rd_val_o, 1'b1);
        check("raw_rd_dat", rd_dat_o, 128'h1234);

        // last contended grant was write; uncontended grants since then leave it
        wr_val_i = 1'b1;
        rd_val_i = 1'b1;
        #1;
        check("rr2_wr", wr_rdy_o, 1'b0);
        check("rr2_rd", rd_rdy_o, 1'b1);
        step();
        wr_val_i = 1'b0;
        rd_val_i = 1'b0;
        step_extra();
        check("rr2_rd_val", rd_val_o, 1'b1);
        check("rr2_rd_dat", rd_dat_o, 128'h1234);
        step();

        // clear mid-traffic
        wr_val_i = 1'b1;
        wr_adr_i = 5'd0;
        wr_dat_i = 128'hDEADBEEF;
        #1;
        check("clr_fill_rdy", wr_rdy_o, 1'b1);
        step();
        wr_val_i = 1'b0;
        rd_val_i = 1'b1;
        rd_adr_i = 5'd0;
        clr_i    = 1'b1;
        #1;
        check("clr_no_gnt", rd_rdy_o, 1'b0);
        check("clr_done_still", init_done_o, 1'b1);
        step();
        clr_i = 1'b0;
        #1;
        check("clr_done_fall", init_done_o, 1'b0);
        for (int i = 0; i < 32; i++) begin
            check("clr_rdy_low", rd_rdy_o, 1'b0);
            step();
        end
        check("clr_done_rise", init_done_o, 1'b1);
        check("clr_rd_rdy", rd_rdy_o, 1'b1);
        step();
        rd_val_i = 1'b0;
        step_extra();
        check("clr_rd_val", rd_val_o, 1'b1);
        check("clr_rd_dat", rd_dat_o, 128'h0);

        // reset during INIT
        wr_val_i = 1'b1;
        wr_adr_i = 5'd5;
        wr_dat_i = 128'hCAFE;
        step();
        wr_val_i = 1'b0;
        rd_val_i = 1'b1;
        rd_adr_i = 5'd5;
        step();
        rd_val_i = 1'b0;
        step_extra();
        check("ri_pre_dat", rd_dat_o, 128'hCAFE);
        clr_i = 1'b1;
        step();
        clr_i = 1'b0;
        for (int i = 0; i < 10; i++) step();
        wr_val_i = 1'b1;
        wr_adr_i = 5'd9;
        wr_dat_i = 128'h99;
        rd_val_i = 1'b1;
        rd_adr_i = 5'd5;
        rstn     = 1'b0;
        #1;
        check("ri_wr_rdy", wr_rdy_o, 1'b0);
        check("ri_rd_rdy", rd_rdy_o, 1'b0);
        check("ri_done", init_done_o, 1'b0);
        check("ri_rd_val", rd_val_o, 1'b0);
        check("ri_rd_dat", rd_dat_o, 128'h0);
        step();
        rstn = 1'b1;
        for (int i = 0; i < 32; i++) begin
            check("ri_init_done_low", init_done_o, 1'b0);
            check("ri_init_wr_rdy_low", wr_rdy_o, 1'b0);
            step();
        end
        check("ri_done_rise", init_done_o, 1'b1);
        check("ri_cont_wr", wr_rdy_o, 1'b1);
        check("ri_cont_rd", rd_rdy_o, 1'b0);
        step();
        wr_val_i = 1'b0;
        #1;
        check("ri_rd_rdy_after", rd_rdy_o, 1'b1);
        step();
        rd_adr_i = 5'd9;
        step_extra();
        check("ri_cleared_val", rd_val_o, 1'b1);
        check("ri_cleared_dat", rd_dat_o, 128'h0);
        step();
        rd_val_i = 1'b0;
        step_extra();
        check("ri_new_val", rd_val_o, 1'b1);
        check("ri_new_dat", rd_dat_o, 128'h99);

        // async reset clears a pending read output immediately
        rstn = 1'b0;
        #1;
        check("ar_rd_val", rd_val_o, 1'b0);
        check("ar_rd_dat", rd_dat_o, 128'h0);
        check("ar_done", init_done_o, 1'b0);
        step();
        rstn = 1'b1;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_ram_1p_arb.md
# fetch_ram_1p_arb

Parametrised single-port fetch buffer that generalises the fixed 128x32 fetch RAM. It keeps a behavioural storage array of `2**ADDR_WIDTH` words of `WORD_WIDTH` bits. A write requester (the DDR fetch side) and a read requester (the prediction/ME side) share that one port through valid/ready handshakes and round-robin arbitration. Byte-masked writes are supported, and a built-in clear sequencer zeroes the array after reset or on request. It sits between the fetch engine and its consumers in place of the hard-wired fetch RAM wrappers.

## Interface
- `WORD_WIDTH`, 128, data word width in bits; must be a multiple of 8
- `ADDR_WIDTH`, 5, address width; depth = `2**ADDR_WIDTH`
- `MASK_WIDTH`, `WORD_WIDTH/8`, byte-enable width; derived, not overridden
- `clk` input 1: single clock, rising edge
- `rstn` input 1: asynchronous, active-low reset
- `clr_i` input 1: single-cycle pulse that restarts the clear sweep
- `init_done_o` output 1: high when the array is cleared and the port is serving requests
- `wr_val_i` input 1: write request valid
- `wr_rdy_o` output 1: write request accepted this cycle
- `wr_adr_i` input `ADDR_WIDTH`: write address
- `wr_msk_i` input `MASK_WIDTH`: byte enables, 1 = write that byte
- `wr_dat_i` input `WORD_WIDTH`: write data
- `rd_val_i` input 1: read request valid
- `rd_rdy_o` output 1: read request accepted this cycle
- `rd_adr_i` input `ADDR_WIDTH`: read address
- `rd_val_o` output 1: read data valid
- `rd_dat_o` output `WORD_WIDTH`: read data

## Operation
- **States:**
  - INIT: sweep counter `cnt` writes 0 to word `cnt` each cycle.
  - IDLE: serve requests.
- **Reset:** enter INIT with `cnt`=0.
- **INIT:**
  - `wr_rdy_o`=`rd_rdy_o`=0; requests are held by the requesters, not dropped.
  - When `cnt`=`2**ADDR_WIDTH-1` is written, the next state is IDLE.
  - Total duration is exactly `2**ADDR_WIDTH` cycles.
- **IDLE:**
  - Handshake: a transfer occurs when val && rdy in the same cycle.
  - `rdy` is combinational from `val` and arbitration state; `val` must not depend on `rdy`.
  - Only one requester valid: that requester is granted.
  - Both requesters valid: grant goes to the requester not granted last (`last_gnt` register; reset value = read, so the first contention grants write).
  - `last_gnt` updates only on a contended grant.
- **Write:** byte `i` of `mem[wr_adr_i]` is updated iff `wr_msk_i[i]`; other bytes keep their value. A mask of all zeros is a legal no-op that still completes the handshake.
- **Read:** `mem[rd_adr_i]` is captured into the output register. `rd_dat_o` holds its last value until the next read completes.
- **Read after write:**
  - A read of an address written in any earlier cycle returns the new data.
  - Same-cycle read and write is impossible because there is a single grant.
- **`clr_i`:**
  - In IDLE: next state is INIT and `cnt`=0. No grant is issued in the `clr_i` cycle.
  - In INIT: `cnt` restarts at 0.
  - A read already in the output pipeline still completes.
- **Reset mid-operation:** pending `rd_val_o` is cleared immediately; array contents are don't-care until INIT completes.

## Timing
- **Reset values:**
  - `wr_rdy_o`=0, `rd_rdy_o`=0
  - `init_done_o`=0
  - `rd_val_o`=0
  - `rd_dat_o`=0
- **`init_done_o`:**
  - Registered.
  - Rises the cycle after the last INIT write: `2**ADDR_WIDTH` cycles after `rstn` deasserts.
  - Falls the cycle after `clr_i`.
- **Read latency:** granted at edge N means `rd_val_o`=1 with data after edge N+1, for one cycle per accepted read. There is no output back-pressure; the consumer must sink the data.
- **Throughput:**
  - Write: one accepted write per cycle.
  - Read: one accepted read per cycle.
  - Under continuous contention, the grants alternate.

## Configuration
- **`FETCH_RAM_OUT_REG_EN`:**
  - Defined: one extra output register stage on `rd_dat_o`/`rd_val_o`. Read latency is 2 cycles; `rd_val_o` is pipelined alongside the data.
  - Undefined: latency is 1 cycle as above.
- Arbitration, INIT and handshake behaviour are identical in both builds.

## Test plan
- **Post-reset clear:**
  - With defaults, release `rstn` and hold `rd_val_i`=1 at `rd_adr_i`=7.
  - `rd_rdy_o` stays 0 for 32 cycles; `init_done_o` rises on cycle 32.
  - The read is then granted and returns `rd_dat_o`=0 one cycle later.
- **Masked write:**
  - Write `{16{8'hAA}}` mask all-ones to address 3, then `{16{8'h55}}` mask 16'h00FF to address 3, then read address 3.
  - The read returns bytes 0-7 = 8'h55 and bytes 8-15 = 8'hAA.
- **Contention:**
  - Hold `wr_val_i`=`rd_val_i`=1 for 6 cycles from IDLE with `last_gnt` at its reset value.
  - Grants are W,R,W,R,W,R.
  - `rd_val_o` pulses 1 cycle after each R grant, or 2 with `FETCH_RAM_OUT_REG_EN`.
- **Back-to-back read after write:**
  - Write 128'h1234 to address 31 at cycle N, read address 31 at cycle N+1.
  - `rd_dat_o`=128'h1234 with `rd_val_o`=1 at cycle N+2.
- **Clear mid-traffic:**
  - Fill address 0 with nonzero data, pulse `clr_i` while `rd_val_i`=1.
  - No grant in that cycle; `init_done_o` falls; rdy stays low for 32 cycles.
  - A subsequent read of address 0 returns 0.
- **Reset during INIT:**
  - Assert `rstn`=0 at sweep count 10.
  - All outputs go to reset values immediately.
  - After release, the full 32-cycle INIT reruns before `init_done_o`=1.
